// File: rtl/offset_calibrator_pkg.sv
// Shared types and constants for the ADC offset calibrator.
// The saturation helper clamps a 33-bit negated mean into signed Q16.16.
package offset_calibrator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETTLE  = 2'd1,
    ST_ACCUM   = 2'd2,
    ST_COMPUTE = 2'd3
  } state_t;

  localparam int FRAC_BITS = 16;
  localparam int ADC_W     = 16;
  localparam int OFFSET_W  = 32;

  localparam logic [OFFSET_W-1:0] Q16_16_MAX = 32'h7FFF_FFFF;
  localparam logic [OFFSET_W-1:0] Q16_16_MIN = 32'h8000_0000;

  function automatic logic [OFFSET_W-1:0] sat_q16_16(input logic signed [OFFSET_W:0] v);
    logic [OFFSET_W-1:0] r;
    if (v > $signed({1'b0, Q16_16_MAX}))
      r = Q16_16_MAX;
    else if (v < $signed({1'b1, Q16_16_MIN}))
      r = Q16_16_MIN;
    else
      r = v[OFFSET_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/offset_calibrator_if.sv
// Sample stream, control and result bundle of the offset calibrator.
// slave is the calibrator side, master the driver/consumer side.
interface offset_calibrator_if;
  import offset_calibrator_pkg::*;

  logic signed [ADC_W-1:0] adc_i;
  logic                    adc_valid_i;
  logic                    start_i;
  logic                    abort_i;
  logic [OFFSET_W-1:0]     offset_o;
  logic [ADC_W-1:0]        mean_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    cal_valid_o;

  modport slave (
    input  adc_i, adc_valid_i, start_i, abort_i,
    output offset_o, mean_o, busy_o, done_o, cal_valid_o
  );

  modport master (
    output adc_i, adc_valid_i, start_i, abort_i,
    input  offset_o, mean_o, busy_o, done_o, cal_valid_o
  );

endinterface

// File: rtl/offset_calibrator_accumulator.sv
// Signed sample accumulator with clear/enable and a sample counter.
// last flags that the next enabled sample is the 2^LOG2_N-th one.
module offset_calibrator_accumulator
  import offset_calibrator_pkg::*;
#(
  parameter int LOG2_N = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clr,
  input  logic                           en,
  input  logic signed [ADC_W-1:0]        sample,
  output logic signed [ADC_W+LOG2_N-1:0] sum,
  output logic [LOG2_N:0]                count,
  output logic                           last
);

  localparam int ACC_W = ADC_W + LOG2_N;
  localparam logic [LOG2_N:0] LAST_CNT = {1'b0, {LOG2_N{1'b1}}};
  localparam logic [LOG2_N:0] CNT_ONE  = {{LOG2_N{1'b0}}, 1'b1};

  logic signed [ACC_W-1:0] sample_ext;

  assign sample_ext = $signed({{LOG2_N{sample[ADC_W-1]}}, sample});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum   <= '0;
      count <= '0;
    end else if (clr) begin
      sum   <= '0;
      count <= '0;
    end else if (en) begin
      sum   <= sum + sample_ext;
      count <= count + CNT_ONE;
    end
  end

  assign last = (count == LAST_CNT);

endmodule

// File: rtl/offset_calibrator.sv
// Offset calibration sequencer: settle, average 2^LOG2_N samples, publish -mean.
// Results only move on the COMPUTE edge so the downstream adder never sees glitches.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for start; results hold their last published value
// ST_SETTLE  | discarding the first SETTLE valid samples
// ST_ACCUM   | summing 2^LOG2_N valid samples
// ST_COMPUTE | one cycle; negate/saturate and publish at its closing edge
module offset_calibrator
  import offset_calibrator_pkg::*;
#(
  parameter int LOG2_N = 10,
  parameter int SETTLE = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  offset_calibrator_if.slave  bus
);

  localparam int ACC_W = ADC_W + LOG2_N;
  localparam int SHIFT = FRAC_BITS - LOG2_N;
  localparam logic [15:0] SETTLE_CNT = 16'(SETTLE);

  state_t state, next_state;

  logic acc_clr, acc_en, settle_load, settle_dec, publish;
  logic [15:0] settle_cnt;

  logic signed [ACC_W-1:0] sum;
  logic [LOG2_N:0]         count;
  logic                    last;

  logic signed [OFFSET_W:0] q_mean, q_neg;
  logic [OFFSET_W-1:0]      offset_next;
  logic [ADC_W-1:0]         mean_next;

  logic [OFFSET_W-1:0] offset_q;
  logic [ADC_W-1:0]    mean_q;
  logic                cal_valid_q;
  logic                done_q;

  offset_calibrator_accumulator #(.LOG2_N(LOG2_N)) u_acc (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (acc_clr),
    .en     (acc_en),
    .sample (bus.adc_i),
    .sum    (sum),
    .count  (count),
    .last   (last)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state  = state;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    settle_load = 1'b0;
    settle_dec  = 1'b0;
    publish     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start_i) begin
          acc_clr     = 1'b1;
          settle_load = 1'b1;
          next_state  = (SETTLE == 0) ? ST_ACCUM : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (bus.abort_i) begin
          next_state = ST_IDLE;
        end else if (bus.adc_valid_i) begin
          settle_dec = 1'b1;
          if (settle_cnt == 16'd1) next_state = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (bus.abort_i) begin
          next_state = ST_IDLE;
        end else if (bus.adc_valid_i) begin
          acc_en = 1'b1;
          if (last) next_state = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        next_state = ST_IDLE;
        publish    = !bus.abort_i;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Settle interval as a down-counter; terminal count is the last discarded sample.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)            settle_cnt <= '0;
    else if (settle_load) settle_cnt <= SETTLE_CNT;
    else if (settle_dec)  settle_cnt <= settle_cnt - 16'd1;
  end

  // sum / 2^LOG2_N in Q16.16 keeps the fractional bits; -(-32768) is the only overflow.
  assign q_mean      = $signed({{(OFFSET_W + 1 - ACC_W){sum[ACC_W-1]}}, sum}) <<< SHIFT;
  assign q_neg       = -q_mean;
  assign offset_next = sat_q16_16(q_neg);
  assign mean_next   = sum[LOG2_N +: ADC_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      offset_q    <= '0;
      mean_q      <= '0;
      cal_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= publish;
      if (publish) begin
        offset_q    <= offset_next;
        mean_q      <= mean_next;
        cal_valid_q <= 1'b1;
      end
    end
  end

  assign bus.offset_o    = offset_q;
  assign bus.mean_o      = mean_q;
  assign bus.cal_valid_o = cal_valid_q;
  assign bus.done_o      = done_q;
  assign bus.busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_offset_calibrator.sv
// Bench for offset_calibrator (LOG2_N=4, SETTLE=2): table vectors, control corner
// sequences and randomized runs checked against an arithmetic reference model.
module tb_offset_calibrator;
  import offset_calibrator_pkg::*;

  localparam int LOG2_N = 4;
  localparam int SETTLE = 2;
  localparam int N      = 16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  offset_calibrator_if bus();

  offset_calibrator #(.LOG2_N(LOG2_N), .SETTLE(SETTLE)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  logic signed [15:0] smp [N];

  always @(negedge clk_i) if (bus.done_o === 1'b1) done_seen++;

  typedef struct {
    logic signed [15:0] a;
    logic signed [15:0] b;
    int                 gap;
    logic [31:0]        off;
    logic [15:0]        mean;
  } vec_t;

  vec_t vt [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Exact mean is sum/16; Q16.16 of -mean is -sum*4096; floor division for mean_o.
  function automatic void model(output logic [31:0] off, output logic [15:0] mn);
    longint s, m, o;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(smp[i]);
    m = s / N;
    if (s < 0 && (s % N) != 0) m = m - 1;
    o = -s * 4096;
    if (o > 64'sd2147483647) o = 64'sd2147483647;
    off = o[31:0];
    mn  = m[15:0];
  endfunction

  task automatic run_cal(input int gap_mode, input int abort_at, input bit restart_mid,
                         input logic [31:0] exp_off, input logic [15:0] exp_mean,
                         input string tag);
    int idx;
    int cyc;
    int d0;
    bit v;
    bit ab;
    bit aborted;
    idx = 0;
    cyc = 0;
    aborted = 0;
    d0 = done_seen;
    bus.adc_valid_i = 1'b0;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    check({tag, "_busy_after_start"}, 32'(bus.busy_o), 32'd1);
    while (idx < SETTLE + N && !aborted) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = cyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      ab = (abort_at > 0) && v && (idx == SETTLE + abort_at - 1);
      bus.adc_valid_i = v;
      bus.adc_i = (v && idx >= SETTLE) ? smp[idx - SETTLE] : 16'($urandom);
      bus.abort_i = ab;
      bus.start_i = restart_mid && (idx == SETTLE + N / 2);
      step();
      bus.abort_i = 1'b0;
      bus.start_i = 1'b0;
      if (v) idx++;
      if (ab) aborted = 1;
      cyc++;
      if (cyc > 400) begin
        check({tag, "_sample_timeout"}, 32'(cyc), 32'd0);
        bus.adc_valid_i = 1'b0;
        return;
      end
    end
    bus.adc_valid_i = 1'b0;
    if (aborted) begin
      check({tag, "_busy_after_abort"}, 32'(bus.busy_o), 32'd0);
      check({tag, "_offset_kept"}, bus.offset_o, exp_off);
      check({tag, "_mean_kept"}, 32'(bus.mean_o), 32'(exp_mean));
      repeat (4) step();
      check({tag, "_no_done"}, 32'(done_seen - d0), 32'd0);
      return;
    end
    check({tag, "_busy_compute"}, 32'(bus.busy_o), 32'd1);
    check({tag, "_done_early"}, 32'(bus.done_o), 32'd0);
    step();
    check({tag, "_done"}, 32'(bus.done_o), 32'd1);
    check({tag, "_offset"}, bus.offset_o, exp_off);
    check({tag, "_mean"}, 32'(bus.mean_o), 32'(exp_mean));
    check({tag, "_cal_valid"}, 32'(bus.cal_valid_o), 32'd1);
    check({tag, "_idle"}, 32'(bus.busy_o), 32'd0);
    step();
    check({tag, "_done_one_cycle"}, 32'(bus.done_o), 32'd0);
    check({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
  endtask

  initial begin
    logic [31:0] eo;
    logic [15:0] em;

    vt[0] = '{16'sd100,    16'sd100,    0, 32'hFF9C_0000, 16'h0064};
    vt[1] = '{16'sd1,      16'sd2,      1, 32'hFFFE_8000, 16'h0001};
    vt[2] = '{16'sh8000,   16'sh8000,   0, 32'h7FFF_FFFF, 16'h8000};
    vt[3] = '{-16'sd3,     -16'sd4,     1, 32'h0003_8000, 16'hFFFC};
    vt[4] = '{16'sh7FFF,   16'sh7FFF,   0, 32'h8001_0000, 16'h7FFF};
    vt[5] = '{-16'sd1,     16'sd0,      0, 32'h0000_8000, 16'hFFFF};
    vt[6] = '{16'sd100,    16'sd100,    0, 32'hFF9C_0000, 16'h0064};

    bus.adc_i = '0;
    bus.adc_valid_i = 1'b0;
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;

    #2;
    check("rst_offset", bus.offset_o, 32'd0);
    check("rst_mean", 32'(bus.mean_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_done", 32'(bus.done_o), 32'd0);
    check("rst_cal_valid", 32'(bus.cal_valid_o), 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    step();

    for (int k = 0; k < 7; k++) begin
      for (int i = 0; i < N; i++) smp[i] = (i % 2 == 0) ? vt[k].a : vt[k].b;
      run_cal(vt[k].gap, 0, 1'b0, vt[k].off, vt[k].mean, $sformatf("vec%0d", k));
    end

    // Abort on the 8th accumulated sample; previous results must survive.
    for (int i = 0; i < N; i++) smp[i] = 16'sd5;
    run_cal(0, 8, 1'b0, 32'hFF9C_0000, 16'h0064, "abort");

    // Start re-pulsed mid-accumulation is ignored.
    for (int i = 0; i < N; i++) smp[i] = 16'($urandom);
    model(eo, em);
    run_cal(2, 0, 1'b1, eo, em, "restart_ignored");

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        smp[i] = (r < 4) ? 16'($urandom) : 16'($urandom_range(0, 600)) - 16'sd300;
      model(eo, em);
      run_cal(2, 0, 1'b0, eo, em, $sformatf("rand%0d", r));
    end

    // Asynchronous reset in the middle of the settle interval.
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    bus.adc_valid_i = 1'b1;
    bus.adc_i = 16'sd7;
    step();
    bus.adc_valid_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst_offset", bus.offset_o, 32'd0);
    check("midrst_mean", 32'(bus.mean_o), 32'd0);
    check("midrst_cal_valid", 32'(bus.cal_valid_o), 32'd0);
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    for (int i = 0; i < N; i++) smp[i] = 16'sd100;
    run_cal(0, 0, 1'b0, 32'hFF9C_0000, 16'h0064, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
